// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: state encoding,
// opcode values, IR field positions, the output control bundle and opcode classifiers.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8,
        ST_FAULT  = 4'd9
    } cu_state_e;

    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_SHR  = 5'b00111;
    localparam logic [4:0] OPC_SHRA = 5'b01000;
    localparam logic [4:0] OPC_SHL  = 5'b01001;
    localparam logic [4:0] OPC_ROR  = 5'b01010;
    localparam logic [4:0] OPC_ROL  = 5'b01011;
    localparam logic [4:0] OPC_MUL  = 5'b01111;
    localparam logic [4:0] OPC_DIV  = 5'b10000;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam int IR_OPC_LSB = 27;
    localparam int IR_RA_LSB  = 23;
    localparam int IR_RB_LSB  = 19;
    localparam int IR_RC_LSB  = 15;
    localparam int REG_IDX_W  = 4;

    typedef struct packed {
        logic pc_select;
        logic mar_enable;
        logic pc_increment_enable;
        logic z_enable;
        logic z_lo_select;
        logic z_hi_select;
        logic pc_enable;
        logic read;
        logic mdr_enable;
        logic mdr_select;
        logic ir_enable;
        logic y_enable;
        logic hi_enable;
        logic lo_enable;
    } ctrl_t;

    function automatic logic is_alu_rformat(input logic [4:0] opc);
        logic r;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
            OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_mul_div(input logic [4:0] opc);
        return (opc == OPC_MUL) || (opc == OPC_DIV);
    endfunction

    function automatic logic is_defined(input logic [4:0] opc);
        return is_alu_rformat(opc) || is_mul_div(opc) || (opc == OPC_NOP) || (opc == OPC_HALT);
    endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Register index to one-hot enable decoder; all-zero when not enabled.
module reg_field_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot
);

    // One-hot decode of the selected register
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = '0;
        end
    end

endmodule

// File: rtl/alu_control_unit.sv
// Hardwired fetch/execute control sequencer. Outputs are registered from the next state.
// Optional macro CU_ILLEGAL_TRAP_EN: undefined opcodes trap into a sticky FAULT state.
module alu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run_req,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    output logic                PC_select,
    output logic                MAR_enable,
    output logic                PC_increment_enable,
    output logic                Z_enable,
    output logic                Z_LO_select,
    output logic                Z_HI_select,
    output logic                PC_enable,
    output logic                read,
    output logic                MDR_enable,
    output logic                MDR_select,
    output logic                IR_enable,
    output logic                Y_enable,
    output logic                HI_enable,
    output logic                LO_enable,
    output logic [NUM_REGS-1:0] reg_in,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [OPC_W-1:0]    alu_instruction,
    output logic                running,
    output logic                halted,
    output logic                fault
);

    cu_state_e              state_r, state_s, end_s;
    logic [OPC_W-1:0]       opc_r, opc_s;
    logic [REG_IDX_W-1:0]   ra_r, rb_r, rc_r, ra_s, rb_s, rc_s;
    ctrl_t                  ctrl_r, ctrl_s;
    logic [OPC_W-1:0]       alu_r, alu_s;
    logic [NUM_REGS-1:0]    reg_in_r, reg_out_r, reg_in_s, reg_out_s;
    logic [REG_IDX_W-1:0]   in_idx_s, out_idx_s;
    logic                   in_en_s, out_en_s;
    logic                   running_r, halted_r, fault_r, running_s, halted_s, fault_s;
    logic                   unused_ir_s;

    assign unused_ir_s = ^ir[IR_RC_LSB-1:0];

    // Next-state logic; the instruction always completes once started
    always_comb begin
        state_s = state_r;
        end_s   = run_req ? ST_T0 : ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (run_req) state_s = ST_T0;
                else         state_s = ST_IDLE;
            end
            ST_T0:   state_s = ST_T1;
            ST_T1: begin
                if (mem_ready) state_s = ST_T2;
                else           state_s = ST_T1;
            end
            ST_T2:   state_s = ST_T3;
            ST_T3: begin
                if (is_alu_rformat(opc_r) || is_mul_div(opc_r)) state_s = ST_T4;
                else if (opc_r == OPC_HALT)                      state_s = ST_HALTED;
                else if (is_defined(opc_r))                      state_s = end_s;
`ifdef CU_ILLEGAL_TRAP_EN
                else                                             state_s = ST_FAULT;
`else
                else                                             state_s = end_s;
`endif
            end
            ST_T4:   state_s = ST_T5;
            ST_T5: begin
                if (is_mul_div(opc_r)) state_s = ST_T6;
                else                   state_s = end_s;
            end
            ST_T6:     state_s = end_s;
            ST_HALTED: state_s = ST_HALTED;
            ST_FAULT:  state_s = ST_FAULT;
            default:   state_s = ST_IDLE;
        endcase
    end

    // IR fields are captured only on the T2->T3 edge
    always_comb begin
        if (state_r == ST_T2) begin
            opc_s = ir[IR_OPC_LSB +: OPC_W];
            ra_s  = ir[IR_RA_LSB +: REG_IDX_W];
            rb_s  = ir[IR_RB_LSB +: REG_IDX_W];
            rc_s  = ir[IR_RC_LSB +: REG_IDX_W];
        end else begin
            opc_s = opc_r;
            ra_s  = ra_r;
            rb_s  = rb_r;
            rc_s  = rc_r;
        end
    end

    // Output decode for the upcoming state, so registered outputs line up with state_r
    always_comb begin
        ctrl_s    = '0;
        alu_s     = '0;
        in_idx_s  = '0;
        out_idx_s = '0;
        in_en_s   = 1'b0;
        out_en_s  = 1'b0;
        running_s = (state_s != ST_IDLE) && (state_s != ST_HALTED) && (state_s != ST_FAULT);
        halted_s  = (state_s == ST_HALTED);
        fault_s   = 1'b0;
        case (state_s)
            ST_T0: begin
                ctrl_s.pc_select           = 1'b1;
                ctrl_s.mar_enable          = 1'b1;
                ctrl_s.pc_increment_enable = 1'b1;
                ctrl_s.z_enable            = 1'b1;
            end
            ST_T1: begin
                ctrl_s.z_lo_select = 1'b1;
                ctrl_s.read        = 1'b1;
                ctrl_s.mdr_enable  = 1'b1;
                ctrl_s.pc_enable   = (state_r == ST_T0);
            end
            ST_T2: begin
                ctrl_s.mdr_select = 1'b1;
                ctrl_s.ir_enable  = 1'b1;
            end
            ST_T3: begin
                ctrl_s.y_enable = is_alu_rformat(opc_s) || is_mul_div(opc_s);
                out_en_s        = ctrl_s.y_enable;
                out_idx_s       = is_mul_div(opc_s) ? ra_s : rb_s;
            end
            ST_T4: begin
                ctrl_s.z_enable = 1'b1;
                alu_s           = opc_s;
                out_en_s        = 1'b1;
                out_idx_s       = is_mul_div(opc_s) ? rb_s : rc_s;
            end
            ST_T5: begin
                ctrl_s.z_lo_select = 1'b1;
                ctrl_s.lo_enable   = is_mul_div(opc_s);
                in_en_s            = is_alu_rformat(opc_s);
                in_idx_s           = ra_s;
            end
            ST_T6: begin
                ctrl_s.z_hi_select = 1'b1;
                ctrl_s.hi_enable   = 1'b1;
            end
`ifdef CU_ILLEGAL_TRAP_EN
            ST_FAULT: fault_s = 1'b1;
`endif
            default: ctrl_s = '0;
        endcase
    end

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_dec_in (
        .idx    (in_idx_s),
        .en     (in_en_s),
        .onehot (reg_in_s)
    );

    reg_field_decoder #(.NUM_REGS(NUM_REGS)) u_dec_out (
        .idx    (out_idx_s),
        .en     (out_en_s),
        .onehot (reg_out_s)
    );

    // State, latched IR fields and registered outputs; reset aborts with everything cleared
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_r   <= ST_IDLE;
            opc_r     <= '0;
            ra_r      <= '0;
            rb_r      <= '0;
            rc_r      <= '0;
            ctrl_r    <= '0;
            alu_r     <= '0;
            reg_in_r  <= '0;
            reg_out_r <= '0;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            state_r   <= state_s;
            opc_r     <= opc_s;
            ra_r      <= ra_s;
            rb_r      <= rb_s;
            rc_r      <= rc_s;
            ctrl_r    <= ctrl_s;
            alu_r     <= alu_s;
            reg_in_r  <= reg_in_s;
            reg_out_r <= reg_out_s;
            running_r <= running_s;
            halted_r  <= halted_s;
            fault_r   <= fault_s;
        end
    end

    assign PC_select           = ctrl_r.pc_select;
    assign MAR_enable          = ctrl_r.mar_enable;
    assign PC_increment_enable = ctrl_r.pc_increment_enable;
    assign Z_enable            = ctrl_r.z_enable;
    assign Z_LO_select         = ctrl_r.z_lo_select;
    assign Z_HI_select         = ctrl_r.z_hi_select;
    assign PC_enable           = ctrl_r.pc_enable;
    assign read                = ctrl_r.read;
    assign MDR_enable          = ctrl_r.mdr_enable;
    assign MDR_select          = ctrl_r.mdr_select;
    assign IR_enable           = ctrl_r.ir_enable;
    assign Y_enable            = ctrl_r.y_enable;
    assign HI_enable           = ctrl_r.hi_enable;
    assign LO_enable           = ctrl_r.lo_enable;
    assign reg_in              = reg_in_r;
    assign reg_out             = reg_out_r;
    assign alu_instruction     = alu_r;
    assign running             = running_r;
    assign halted              = halted_r;
    assign fault               = fault_r;

endmodule

// File: tb/tb_alu_control_unit.sv
// Randomized self-checking bench: expected per-cycle control vectors are built
// from the instruction micro-step tables and compared against all DUT outputs.
module tb_alu_control_unit;

    logic        clk = 1'b0;
    logic        clr, run_req, mem_ready;
    logic [31:0] ir;
    logic PC_select, MAR_enable, PC_increment_enable, Z_enable, Z_LO_select, Z_HI_select, PC_enable;
    logic read, MDR_enable, MDR_select, IR_enable, Y_enable, HI_enable, LO_enable;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  alu_instruction;
    logic        running, halted, fault;

    int checks   = 0;
    int failures = 0;
    int post     = 0;

    localparam logic [13:0] C_PCSEL = 14'h2000, C_MAR = 14'h1000, C_PCINC = 14'h0800, C_ZEN = 14'h0400;
    localparam logic [13:0] C_ZLO = 14'h0200, C_ZHI = 14'h0100, C_PCEN = 14'h0080, C_READ = 14'h0040;
    localparam logic [13:0] C_MDREN = 14'h0020, C_MDRSEL = 14'h0010, C_IREN = 14'h0008, C_YEN = 14'h0004;
    localparam logic [13:0] C_HIEN = 14'h0002, C_LOEN = 14'h0001;

    alu_control_unit dut (
        .clk(clk), .clr(clr), .run_req(run_req), .ir(ir), .mem_ready(mem_ready),
        .PC_select(PC_select), .MAR_enable(MAR_enable), .PC_increment_enable(PC_increment_enable),
        .Z_enable(Z_enable), .Z_LO_select(Z_LO_select), .Z_HI_select(Z_HI_select),
        .PC_enable(PC_enable), .read(read), .MDR_enable(MDR_enable), .MDR_select(MDR_select),
        .IR_enable(IR_enable), .Y_enable(Y_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
        .reg_in(reg_in), .reg_out(reg_out), .alu_instruction(alu_instruction),
        .running(running), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [53:0] obs;
    assign obs = {PC_select, MAR_enable, PC_increment_enable, Z_enable, Z_LO_select, Z_HI_select,
                  PC_enable, read, MDR_enable, MDR_select, IR_enable, Y_enable, HI_enable, LO_enable,
                  reg_in, reg_out, alu_instruction, running, halted, fault};

    task automatic check_eq(input string tag, input logic [53:0] got, input logic [53:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [53:0] mk(input logic [13:0] ctl, input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [4:0] alu, input logic run, input logic hlt, input logic flt);
        return {ctl, rin, rout, alu, run, hlt, flt};
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra, input int rb, input int rc);
        return {op, 4'(ra), 4'(rb), 4'(rc), 15'(0)};
    endfunction

    task automatic do_reset();
        clr = 1'b0; run_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        check_eq("reset", obs, '0);
        clr = 1'b1;
        post = 0;
    endtask

    // Runs one instruction: builds the expected cycle list from the opcode's micro-steps
    task automatic run_instr(input logic [31:0] ir_v, input int waits, input logic end_rr, input int abort_at);
        logic [53:0] q[$];
        logic        mq[$];
        string       tq[$];
        logic [4:0]  op = ir_v[31:27];
        logic [15:0] ra = 16'd1 << ir_v[26:23];
        logic [15:0] rb = 16'd1 << ir_v[22:19];
        logic [15:0] rc = 16'd1 << ir_v[18:15];
        logic        alu_op = (op >= 5'd3 && op <= 5'd11);
        logic        md_op  = (op == 5'b01111 || op == 5'b10000);
        logic        legal  = alu_op || md_op || op == 5'b11010 || op == 5'b11011;
        int          t2 = waits + 2;
        if (post == 0) begin
            int n = $urandom_range(0, 2);
            for (int k = 0; k <= n; k++) begin
                check_eq("idle", obs, '0);
                run_req = (k == n); mem_ready = 1'($urandom); ir = $urandom;
                @(negedge clk);
            end
        end
        q.push_back(mk(C_PCSEL | C_MAR | C_PCINC | C_ZEN, '0, '0, '0, 1, 0, 0)); mq.push_back(1'($urandom)); tq.push_back("T0");
        for (int k = 0; k <= waits; k++) begin
            q.push_back(mk(C_ZLO | C_READ | C_MDREN | ((k == 0) ? C_PCEN : 14'h0), '0, '0, '0, 1, 0, 0));
            mq.push_back(k == waits); tq.push_back("T1");
        end
        q.push_back(mk(C_MDRSEL | C_IREN, '0, '0, '0, 1, 0, 0)); mq.push_back(1'($urandom)); tq.push_back("T2");
        if (alu_op) begin
            q.push_back(mk(C_YEN, '0, rb, '0, 1, 0, 0)); tq.push_back("T3alu");
            q.push_back(mk(C_ZEN, '0, rc, op, 1, 0, 0)); tq.push_back("T4alu");
            q.push_back(mk(C_ZLO, ra, '0, '0, 1, 0, 0)); tq.push_back("T5alu");
        end else if (md_op) begin
            q.push_back(mk(C_YEN, '0, ra, '0, 1, 0, 0)); tq.push_back("T3md");
            q.push_back(mk(C_ZEN, '0, rb, op, 1, 0, 0)); tq.push_back("T4md");
            q.push_back(mk(C_ZLO | C_LOEN, '0, '0, '0, 1, 0, 0)); tq.push_back("T5md");
            q.push_back(mk(C_ZHI | C_HIEN, '0, '0, '0, 1, 0, 0)); tq.push_back("T6md");
        end else begin
            q.push_back(mk('0, '0, '0, '0, 1, 0, 0)); tq.push_back("T3nop");
        end
        while (mq.size() < q.size()) mq.push_back(1'($urandom));
        for (int i = 0; i < q.size(); i++) begin
            check_eq(tq[i], obs, q[i]);
            if (i == abort_at) begin
                clr = 1'b0; run_req = 1'b0;
                @(negedge clk);
                check_eq("abort", obs, '0);
                clr = 1'b1; post = 0;
                return;
            end
            run_req   = (i == q.size() - 1) ? end_rr : 1'($urandom);
            mem_ready = mq[i];
            ir        = (i == t2) ? ir_v : $urandom;
            @(negedge clk);
        end
        if (op == 5'b11011) post = 2;
`ifdef CU_ILLEGAL_TRAP_EN
        else if (!legal) post = 3;
`endif
        else post = end_rr ? 1 : 0;
        if (!legal && post != 3) check_eq("illegal_no_fault", {53'd0, fault}, '0);
    endtask

    logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                                   5'b01010, 5'b01011, 5'b01111, 5'b10000, 5'b11010, 5'b11010};

    initial begin
        clr = 1'b0; run_req = 1'b0; mem_ready = 1'b0; ir = '0;
        repeat (3) @(negedge clk);
        check_eq("reset", obs, '0);
        clr = 1'b1;

        run_instr(32'h28918000, 0, 1'b1, -1);
        run_instr(32'h28918000, 3, 1'b1, -1);
        run_instr(mk_ir(5'b01111, 5, 6, 0), 1, 1'b0, -1);
        run_instr(mk_ir(5'b00011, 4, 4, 4), 2, 1'b1, -1);
        run_instr(mk_ir(5'b10000, 15, 0, 9), 0, 1'b1, -1);

        for (int n = 0; n < 60; n++) begin
            run_instr(mk_ir(legal_ops[$urandom_range(0, 12)], $urandom_range(0, 15), $urandom_range(0, 15),
                            $urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom), -1);
        end

        run_instr(32'h28918000, 0, 1'b1, 4);

        run_instr(mk_ir(5'b11111, 1, 2, 3), 1, 1'b1, -1);
        if (post == 3) begin
            for (int k = 0; k < 6; k++) begin
                check_eq("fault_hold", obs, mk('0, '0, '0, '0, 0, 0, 1));
                run_req = 1'($urandom);
                @(negedge clk);
            end
        end else begin
            run_instr(mk_ir(5'b00110, 7, 8, 9), 0, 1'b1, -1);
        end
        do_reset();

        run_instr(mk_ir(5'b11011, 0, 0, 0), 1, 1'b1, -1);
        for (int k = 0; k < 10; k++) begin
            check_eq("halt_hold", obs, mk('0, '0, '0, '0, 0, 1, 0));
            run_req = 1'b1;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
